// File: rtl/tank_turn_ctrl.sv
// rtl/tank_turn_ctrl.sv - turn sequencing and game state for a two-tank artillery game
//
// Purpose:
//    Holds both tanks' x positions, aim angles and scores and runs the turn
//    sequence IDLE -> AIM -> LAUNCH -> FLIGHT -> SWAP -> AIM (or OVER).
//    A shot is offered to the projectile block over shot_valid/shot_ready,
//    then the block waits for shot_done/shot_hit.
//    Optional feature macro: TURN_TIMEOUT_EN (AIM-state turn timeout of
//    TURN_CYCLES cycles; without it AIM waits indefinitely).
//
// Ports:
//    clk, reset                         clock, asynchronous active-low reset
//    left_x, right_x                    move pulses for the active tank
//    left_aim, right_aim                angle down/up pulses
//    shoot_in                           fire pulse
//    new_game                           restart strobe (overrides all events)
//    shot_ready, shot_done, shot_hit    projectile block handshake/result
//    shot_valid, shot_x, shot_angle,
//    shot_dir                           shot offer and its payload
//    p0_x, p1_x, p0_angle, p1_angle,
//    p0_score, p1_score                 per-player state
//    active_player, game_over, winner   turn and game status
module tank_turn_ctrl #(
   parameter int X_INIT0     = 2,
   parameter int X_INIT1     = 13,
   parameter int ANGLE_MAX   = 7,
   parameter int MOVE_BUDGET = 3,
   parameter int WIN_SCORE   = 5,
   parameter int TURN_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_x,
   input  logic       right_x,
   input  logic       left_aim,
   input  logic       right_aim,
   input  logic       shoot_in,
   input  logic       new_game,
   input  logic       shot_ready,
   input  logic       shot_done,
   input  logic       shot_hit,
   output logic       shot_valid,
   output logic [3:0] shot_x,
   output logic [2:0] shot_angle,
   output logic       shot_dir,
   output logic [3:0] p0_x,
   output logic [3:0] p1_x,
   output logic [2:0] p0_angle,
   output logic [2:0] p1_angle,
   output logic [2:0] p0_score,
   output logic [2:0] p1_score,
   output logic       active_player,
   output logic       game_over,
   output logic       winner
);

   localparam logic [3:0] X0     = 4'(X_INIT0);
   localparam logic [3:0] X1     = 4'(X_INIT1);
   localparam logic [2:0] ANG0   = 3'(ANGLE_MAX / 2);
   localparam logic [2:0] AMAX   = 3'(ANGLE_MAX);
   localparam logic [2:0] BUDGET = 3'(MOVE_BUDGET);
   localparam logic [2:0] WIN    = 3'(WIN_SCORE);

   typedef enum logic [2:0] {IDLE, AIM, LAUNCH, FLIGHT, SWAP, OVER} state_t;

   state_t     state, state_d;
   logic [2:0] moves_left, moves_left_d;
   logic       shot_valid_d, shot_dir_d, active_d, game_over_d, winner_d;
   logic [3:0] shot_x_d, p0_x_d, p1_x_d;
   logic [2:0] shot_angle_d, p0_angle_d, p1_angle_d, p0_score_d, p1_score_d;

   // Active/opponent views so the move/aim/score logic is written once.
   logic [3:0] act_x, opp_x, move_x;
   logic [2:0] act_angle, act_score, aim_angle, score_inc;
   logic       move_ok;

   assign act_x     = active_player ? p1_x : p0_x;
   assign opp_x     = active_player ? p0_x : p1_x;
   assign act_angle = active_player ? p1_angle : p0_angle;
   assign act_score = active_player ? p1_score : p0_score;

   // A move is legal only if it stays on the 0..15 field and does not land
   // on the opponent; the budget is checked separately.
   assign move_x  = left_x ? (act_x - 4'd1) : (act_x + 4'd1);
   assign move_ok = left_x ? ((act_x != 4'd0)  && (move_x != opp_x))
                           : ((act_x != 4'd15) && (move_x != opp_x));

   assign aim_angle = right_aim ? ((act_angle == AMAX) ? act_angle : act_angle + 3'd1)
                                : ((act_angle == 3'd0) ? act_angle : act_angle - 3'd1);

   assign score_inc = (act_score == 3'd7) ? act_score : act_score + 3'd1;

`ifdef TURN_TIMEOUT_EN
   localparam int TCW = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TURN_CYCLES - 1);

   logic [TCW-1:0] turn_cnt;

   // Counts cycles spent in AIM; any entry into AIM (including a new_game
   // restart while already in AIM) starts again from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         turn_cnt <= '0;
      end else if (state == AIM && state_d == AIM && !new_game) begin
         turn_cnt <= turn_cnt + 1'b1;
      end else begin
         turn_cnt <= '0;
      end
   end
`endif

   always_comb begin
      state_d      = state;
      moves_left_d = moves_left;
      shot_valid_d = shot_valid;
      shot_x_d     = shot_x;
      shot_angle_d = shot_angle;
      shot_dir_d   = shot_dir;
      p0_x_d       = p0_x;
      p1_x_d       = p1_x;
      p0_angle_d   = p0_angle;
      p1_angle_d   = p1_angle;
      p0_score_d   = p0_score;
      p1_score_d   = p1_score;
      active_d     = active_player;
      game_over_d  = game_over;
      winner_d     = winner;

      case (state)
         IDLE: ;
         AIM: begin
            if (shoot_in) begin
               state_d      = LAUNCH;
               shot_valid_d = 1'b1;
               shot_x_d     = act_x;
               shot_angle_d = act_angle;
               shot_dir_d   = active_player;
`ifdef TURN_TIMEOUT_EN
            end else if (turn_cnt == TC_LAST) begin
               state_d = SWAP;
`endif
            end else if (left_x || right_x) begin
               // Any move pulse claims the cycle; aim pulses are dropped and
               // left+right together does nothing.
               if ((left_x != right_x) && (moves_left != 3'd0) && move_ok) begin
                  if (active_player) p1_x_d = move_x;
                  else               p0_x_d = move_x;
                  moves_left_d = moves_left - 3'd1;
               end
            end else if (left_aim != right_aim) begin
               if (active_player) p1_angle_d = aim_angle;
               else               p0_angle_d = aim_angle;
            end
         end
         LAUNCH: begin
            if (shot_ready) begin
               shot_valid_d = 1'b0;
               state_d      = FLIGHT;
            end
         end
         FLIGHT: begin
            if (shot_done) begin
               state_d = SWAP;
               if (shot_hit) begin
                  if (active_player) p1_score_d = score_inc;
                  else               p0_score_d = score_inc;
                  if (score_inc == WIN) begin
                     state_d     = OVER;
                     game_over_d = 1'b1;
                     winner_d    = active_player;
                  end
               end
            end
         end
         SWAP: begin
            active_d     = ~active_player;
            moves_left_d = BUDGET;
            state_d      = AIM;
         end
         OVER: ;
         default: state_d = IDLE;
      endcase

      if (new_game) begin
         state_d      = AIM;
         moves_left_d = BUDGET;
         shot_valid_d = 1'b0;
         shot_x_d     = 4'd0;
         shot_angle_d = 3'd0;
         shot_dir_d   = 1'b0;
         p0_x_d       = X0;
         p1_x_d       = X1;
         p0_angle_d   = ANG0;
         p1_angle_d   = ANG0;
         p0_score_d   = 3'd0;
         p1_score_d   = 3'd0;
         active_d     = 1'b0;
         game_over_d  = 1'b0;
         winner_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         moves_left    <= BUDGET;
         shot_valid    <= 1'b0;
         shot_x        <= 4'd0;
         shot_angle    <= 3'd0;
         shot_dir      <= 1'b0;
         p0_x          <= X0;
         p1_x          <= X1;
         p0_angle      <= ANG0;
         p1_angle      <= ANG0;
         p0_score      <= 3'd0;
         p1_score      <= 3'd0;
         active_player <= 1'b0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         state         <= state_d;
         moves_left    <= moves_left_d;
         shot_valid    <= shot_valid_d;
         shot_x        <= shot_x_d;
         shot_angle    <= shot_angle_d;
         shot_dir      <= shot_dir_d;
         p0_x          <= p0_x_d;
         p1_x          <= p1_x_d;
         p0_angle      <= p0_angle_d;
         p1_angle      <= p1_angle_d;
         p0_score      <= p0_score_d;
         p1_score      <= p1_score_d;
         active_player <= active_d;
         game_over     <= game_over_d;
         winner        <= winner_d;
      end
   end

endmodule

// File: tb/tb_tank_turn_ctrl.sv
// tb/tb_tank_turn_ctrl.sv - directed self-checking bench for tank_turn_ctrl
module tb_tank_turn_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       left_x = 1'b0, right_x = 1'b0, left_aim = 1'b0, right_aim = 1'b0;
   logic       shoot_in = 1'b0, new_game = 1'b0;
   logic       shot_ready = 1'b0, shot_done = 1'b0, shot_hit = 1'b0;
   logic       shot_valid, shot_dir, active_player, game_over, winner;
   logic [3:0] shot_x, p0_x, p1_x;
   logic [2:0] shot_angle, p0_angle, p1_angle, p0_score, p1_score;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] SH = 5'b10000;
   localparam logic [4:0] LX = 5'b01000;
   localparam logic [4:0] RX = 5'b00100;
   localparam logic [4:0] LA = 5'b00010;
   localparam logic [4:0] RA = 5'b00001;

   tank_turn_ctrl #(.TURN_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim),
      .shoot_in(shoot_in), .new_game(new_game),
      .shot_ready(shot_ready), .shot_done(shot_done), .shot_hit(shot_hit),
      .shot_valid(shot_valid), .shot_x(shot_x), .shot_angle(shot_angle), .shot_dir(shot_dir),
      .p0_x(p0_x), .p1_x(p1_x), .p0_angle(p0_angle), .p1_angle(p1_angle),
      .p0_score(p0_score), .p1_score(p1_score),
      .active_player(active_player), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [4:0] p);
      {shoot_in, left_x, right_x, left_aim, right_aim} = p;
      tick();
      {shoot_in, left_x, right_x, left_aim, right_aim} = 5'b0;
   endtask

   // Full shot: offer, accept, resolve, then the SWAP (or OVER hold) cycle.
   task automatic fire(input logic hit);
      step(SH);
      shot_ready = 1'b1;
      tick();
      shot_ready = 1'b0;
      shot_done = 1'b1;
      shot_hit  = hit;
      tick();
      shot_done = 1'b0;
      shot_hit  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({p0_x, p1_x} !== {4'd2, 4'd13}) begin
         errors++; $display("FAIL reset_x got %0d/%0d expected 2/13", p0_x, p1_x);
      end
      checks++;
      if ({p0_angle, p1_angle} !== {3'd3, 3'd3}) begin
         errors++; $display("FAIL reset_angle got %0d/%0d expected 3/3", p0_angle, p1_angle);
      end
      checks++;
      if ({p0_score, p1_score, active_player, shot_valid, game_over, winner, shot_x, shot_angle, shot_dir} !== 23'd0) begin
         errors++; $display("FAIL reset_misc got sc %0d/%0d act %0d sv %0d go %0d expected all 0",
                            p0_score, p1_score, active_player, shot_valid, game_over);
      end
      reset = 1'b1;
      step(RX | SH);
      checks++;
      if ({p0_x, shot_valid} !== {4'd2, 1'b0}) begin
         errors++; $display("FAIL idle_ignore got x %0d sv %0d expected x 2 sv 0", p0_x, shot_valid);
      end
   endtask

   task automatic test_start();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      checks++;
      if ({p0_x, p1_x, p0_angle, p1_angle, active_player, p0_score, p1_score, game_over}
          !== {4'd2, 4'd13, 3'd3, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0}) begin
         errors++; $display("FAIL start_state got x %0d/%0d ang %0d/%0d act %0d go %0d expected 2/13 3/3 0 0",
                            p0_x, p1_x, p0_angle, p1_angle, active_player, game_over);
      end
   endtask

   task automatic test_move_edge();
      logic [4:0] pulses [5];
      logic [3:0] exp_x  [5];
      pulses = '{LX, LX, LX, RX, RX};
      exp_x  = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
      for (int i = 0; i < 5; i++) begin
         step(pulses[i]);
         checks++;
         if (p0_x !== exp_x[i]) begin
            errors++; $display("FAIL move_edge[%0d] got %0d expected %0d", i, p0_x, exp_x[i]);
         end
      end
   endtask

   task automatic test_aim();
      logic [2:0] exp_up [6];
      logic [2:0] exp_dn [8];
      exp_up = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
      exp_dn = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      for (int i = 0; i < 6; i++) begin
         step(RA);
         checks++;
         if (p0_angle !== exp_up[i]) begin
            errors++; $display("FAIL aim_up[%0d] got %0d expected %0d", i, p0_angle, exp_up[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         step(LA);
         checks++;
         if (p0_angle !== exp_dn[i]) begin
            errors++; $display("FAIL aim_down[%0d] got %0d expected %0d", i, p0_angle, exp_dn[i]);
         end
      end
      checks++;
      if (p1_angle !== 3'd3) begin
         errors++; $display("FAIL aim_other got %0d expected 3", p1_angle);
      end
   endtask

   task automatic test_launch();
      shot_ready = 1'b0;
      step(SH | RA);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({shot_valid, shot_x, shot_angle, shot_dir, p0_angle} !== {1'b1, 4'd1, 3'd0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL launch_hold[%0d] got sv %0d x %0d ang %0d dir %0d p0ang %0d expected 1 1 0 0 0",
                               i, shot_valid, shot_x, shot_angle, shot_dir, p0_angle);
         end
         if (i < 2) step(RA);
      end
      shot_ready = 1'b1;
      tick();
      shot_ready = 1'b0;
      checks++;
      if (shot_valid !== 1'b0) begin
         errors++; $display("FAIL launch_accept got sv %0d expected 0", shot_valid);
      end
      shot_done = 1'b1;
      tick();
      shot_done = 1'b0;
      checks++;
      if (active_player !== 1'b0) begin
         errors++; $display("FAIL swap_cycle got act %0d expected 0", active_player);
      end
      tick();
      checks++;
      if ({active_player, p0_score} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL miss_swap got act %0d score %0d expected 1 0", active_player, p0_score);
      end
   endtask

   task automatic test_priority_block();
      shot_done = 1'b1;
      shot_hit  = 1'b1;
      tick();
      shot_done = 1'b0;
      shot_hit  = 1'b0;
      checks++;
      if (p1_score !== 3'd0) begin
         errors++; $display("FAIL stray_done got %0d expected 0", p1_score);
      end
      step(LX | RA);
      checks++;
      if ({p1_x, p1_angle} !== {4'd12, 3'd3}) begin
         errors++; $display("FAIL move_over_aim got x %0d ang %0d expected 12 3", p1_x, p1_angle);
      end
      step(LX | RX);
      checks++;
      if (p1_x !== 4'd12) begin
         errors++; $display("FAIL both_dirs got %0d expected 12", p1_x);
      end
      step(LX); step(LX);
      fire(1'b0);
      step(RX); step(RX); step(RX);
      fire(1'b0);
      step(LX); step(LX); step(LX);
      checks++;
      if ({p0_x, p1_x, active_player} !== {4'd4, 4'd7, 1'b1}) begin
         errors++; $display("FAIL setup got x %0d/%0d act %0d expected 4/7 1", p0_x, p1_x, active_player);
      end
      fire(1'b0);
      step(RX); step(RX); step(RX);
      checks++;
      if (p0_x !== 4'd6) begin
         errors++; $display("FAIL block_opp got %0d expected 6", p0_x);
      end
      step(LX);
      checks++;
      if (p0_x !== 4'd5) begin
         errors++; $display("FAIL block_no_budget got %0d expected 5", p0_x);
      end
      step(LX);
      checks++;
      if (p0_x !== 4'd5) begin
         errors++; $display("FAIL budget_out got %0d expected 5", p0_x);
      end
      fire(1'b0);
   endtask

   task automatic test_win();
      fire(1'b0);
      for (int i = 1; i <= 5; i++) begin
         fire(1'b1);
         checks++;
         if ({p0_score, game_over} !== {3'(i), (i == 5)}) begin
            errors++; $display("FAIL win_hit[%0d] got score %0d go %0d expected %0d %0d",
                               i, p0_score, game_over, i, (i == 5));
         end
         if (i < 5) fire(1'b0);
      end
      checks++;
      if ({winner, active_player, p1_score} !== {1'b0, 1'b0, 3'd0}) begin
         errors++; $display("FAIL win_state got winner %0d act %0d p1 %0d expected 0 0 0",
                            winner, active_player, p1_score);
      end
   endtask

   task automatic test_over_freeze();
      shot_ready = 1'b1;
      step(SH | RX | RA);
      shot_done = 1'b1;
      shot_hit  = 1'b1;
      tick();
      shot_done = 1'b0;
      shot_hit  = 1'b0;
      shot_ready = 1'b0;
      checks++;
      if ({shot_valid, p0_x, p0_angle, p0_score, p1_x, game_over, active_player}
          !== {1'b0, 4'd5, 3'd0, 3'd5, 4'd7, 1'b1, 1'b0}) begin
         errors++; $display("FAIL over_freeze got sv %0d x %0d ang %0d sc %0d p1x %0d go %0d expected 0 5 0 5 7 1",
                            shot_valid, p0_x, p0_angle, p0_score, p1_x, game_over);
      end
   endtask

   task automatic test_restart();
      new_game = 1'b1;
      right_x  = 1'b1;
      tick();
      new_game = 1'b0;
      right_x  = 1'b0;
      checks++;
      if ({p0_x, p1_x, p0_angle, p0_score, p1_score, game_over, active_player}
          !== {4'd2, 4'd13, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL restart got x %0d/%0d ang %0d sc %0d/%0d go %0d expected 2/13 3 0/0 0",
                            p0_x, p1_x, p0_angle, p0_score, p1_score, game_over);
      end
   endtask

   task automatic test_async_reset();
      shot_ready = 1'b0;
      step(SH);
      checks++;
      if (shot_valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset_offer got %0d expected 1", shot_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (shot_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset got %0d expected 0", shot_valid);
      end
      reset = 1'b1;
      tick();
   endtask

`ifdef TURN_TIMEOUT_EN
   task automatic test_timeout();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      repeat (10) tick();
      checks++;
      if (active_player !== 1'b0) begin
         errors++; $display("FAIL timeout_early got %0d expected 0", active_player);
      end
      tick();
      checks++;
      if ({active_player, p0_score, p1_score, shot_valid} !== {1'b1, 3'd0, 3'd0, 1'b0}) begin
         errors++; $display("FAIL timeout_swap got act %0d sc %0d/%0d sv %0d expected 1 0/0 0",
                            active_player, p0_score, p1_score, shot_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef TURN_TIMEOUT_EN
      test_timeout();
`else
      test_start();
      test_move_edge();
      test_aim();
      test_launch();
      test_priority_block();
      test_win();
      test_over_freeze();
      test_restart();
      test_async_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
